prog_interrupt_controller: RTL and testbench



---
 rtl/prog_interrupt_controller.sv | 168 ++++++++++++++++
 tb/tb_prog_interrupt_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_interrupt_controller.sv
// 8259A-style interrupt controller: edge/level requests, mask, nested in-service, fixed/rotating priority.
// Request edge to int_out takes 2 cycles; vector and read data return 1 cycle after ack/rd_en; no backpressure.
module prog_interrupt_controller #(
   parameter int NUM_IRQ      = 8,
   parameter int VECTOR_WIDTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_IRQ-1:0]      irq_in,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic [2:0]              addr,
   input  logic [31:0]             wr_data,
   output logic [31:0]             rd_data,
   output logic                    rd_valid,
   output logic                    int_out,
   input  logic                    int_ack,
   output logic [VECTOR_WIDTH-1:0] vector_out,
   output logic                    vector_valid,
   output logic                    spurious
);
   localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic                    ctrl_level;
   logic                    ctrl_auto_eoi;
   logic                    ctrl_rotate;
   logic [NUM_IRQ-1:0]      mask;
   logic [NUM_IRQ-1:0]      irr;
   logic [NUM_IRQ-1:0]      isr;
   logic [NUM_IRQ-1:0]      prev_irq;
   logic [VECTOR_WIDTH-1:0] vbase;
   logic [IDW-1:0]          prio_ptr;

   logic                    any_elig;
   logic [IDW-1:0]          win;
   logic                    isr_any;
   logic [IDW-1:0]          isr_top;
   logic [NUM_IRQ-1:0]      irr_next;
   logic [NUM_IRQ-1:0]      isr_next;
   logic [IDW-1:0]          ptr_next;
   logic [31:0]             rd_mux;
   logic                    eoi_wr;
   logic                    eoi_idx_ok;
   logic [IDW-1:0]          eoi_idx;
   logic                    unused_wr_data;

   assign unused_wr_data = ^wr_data;
   assign eoi_wr         = wr_en && (addr == 3'd3);
   assign eoi_idx_ok     = (int'(wr_data[4:0]) < NUM_IRQ);
   assign eoi_idx        = IDW'(wr_data[4:0]);

   // Walk channels from highest to lowest priority; the first in-service bit blocks everything below it.
   always_comb begin
      int             start;
      int             ch;
      logic           blocked;
      logic [IDW-1:0] c;
      start    = ctrl_rotate ? (int'(prio_ptr) + 1) % NUM_IRQ : 0;
      ch       = 0;
      c        = '0;
      blocked  = 1'b0;
      any_elig = 1'b0;
      win      = '0;
      isr_any  = 1'b0;
      isr_top  = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         ch = (start + k) % NUM_IRQ;
         c  = IDW'(ch);
         if (isr[c]) begin
            blocked = 1'b1;
            if (!isr_any) begin
               isr_any = 1'b1;
               isr_top = c;
            end
         end
         if (!blocked && irr[c] && !mask[c] && !any_elig) begin
            any_elig = 1'b1;
            win      = c;
         end
      end
   end

   // EOI clear is applied before the ack set so a same-channel set wins.
   always_comb begin
      irr_next = ctrl_level ? irq_in : irr;
      isr_next = isr;
      ptr_next = prio_ptr;
      if (eoi_wr) begin
         if (wr_data[8]) begin
            if (eoi_idx_ok && isr[eoi_idx]) begin
               isr_next[eoi_idx] = 1'b0;
               if (ctrl_rotate) ptr_next = eoi_idx;
            end
         end else if (isr_any) begin
            isr_next[isr_top] = 1'b0;
            if (ctrl_rotate) ptr_next = isr_top;
         end
      end
      if (int_ack && any_elig) begin
         if (!ctrl_level) irr_next[win] = 1'b0;
         if (!ctrl_auto_eoi) isr_next[win] = 1'b1;
         else if (ctrl_rotate) ptr_next = win;
      end
      if (!ctrl_level) irr_next = irr_next | (irq_in & ~prev_irq);
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         3'd0:    rd_mux = {29'd0, ctrl_rotate, ctrl_auto_eoi, ctrl_level};
         3'd1:    rd_mux = 32'(mask);
         3'd2:    rd_mux = 32'(vbase);
         3'd4:    rd_mux = 32'(irr);
         3'd5:    rd_mux = 32'(isr);
         3'd6:    rd_mux = 32'(prio_ptr);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl_level    <= 1'b0;
         ctrl_auto_eoi <= 1'b0;
         ctrl_rotate   <= 1'b0;
         mask          <= '1;
         vbase         <= '0;
         irr           <= '0;
         isr           <= '0;
         prev_irq      <= '0;
         prio_ptr      <= '0;
         int_out       <= 1'b0;
         vector_out    <= '0;
         vector_valid  <= 1'b0;
         spurious      <= 1'b0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
      end else begin
         prev_irq <= irq_in;
         irr      <= irr_next;
         isr      <= isr_next;
         prio_ptr <= ptr_next;
         int_out  <= int_ack ? 1'b0 : any_elig;

         if (wr_en) begin
            case (addr)
               3'd0: begin
                  ctrl_level    <= wr_data[0];
                  ctrl_auto_eoi <= wr_data[1];
                  ctrl_rotate   <= wr_data[2];
               end
               3'd1:    mask  <= wr_data[NUM_IRQ-1:0];
               3'd2:    vbase <= wr_data[VECTOR_WIDTH-1:0];
               default: ;
            endcase
         end

         vector_valid <= int_ack;
         spurious     <= int_ack && !any_elig;
         if (int_ack) begin
            vector_out <= any_elig ? vbase + VECTOR_WIDTH'(win)
                                   : vbase + VECTOR_WIDTH'(NUM_IRQ - 1);
         end

         rd_valid <= rd_en;
         rd_data  <= rd_en ? rd_mux : '0;
      end
   end
endmodule

// File: tb/tb_prog_interrupt_controller.sv
// Directed scoreboard bench for prog_interrupt_controller (8 channels, 8-bit vectors).
`timescale 1ns/1ps
module tb_prog_interrupt_controller;
   logic        clock;
   logic        reset;
   logic [7:0]  irq_in;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        int_out;
   logic        int_ack;
   logic [7:0]  vector_out;
   logic        vector_valid;
   logic        spurious;

   typedef struct {
      logic [7:0] vec;
      logic       spur;
      string      name;
   } vexp_t;

   typedef struct {
      logic [31:0] dat;
      string       name;
   } rexp_t;

   vexp_t vq[$];
   rexp_t rq[$];
   int    total;
   int    bad;

   prog_interrupt_controller #(.NUM_IRQ(8), .VECTOR_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .irq_in(irq_in),
      .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .int_out(int_out),
      .int_ack(int_ack), .vector_out(vector_out),
      .vector_valid(vector_valid), .spurious(spurious)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: every vector or read-data beat is matched against the oldest expectation.
   always @(negedge clock) begin
      vexp_t ve;
      rexp_t re;
      if (vector_valid) begin
         total++;
         if (vq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_vector: got vec=%h spur=%b, none expected", vector_out, spurious);
         end else begin
            ve = vq.pop_front();
            if (vector_out !== ve.vec || spurious !== ve.spur) begin
               bad++;
               $display("FAIL %s: got vec=%h spur=%b, want vec=%h spur=%b",
                        ve.name, vector_out, spurious, ve.vec, ve.spur);
            end
         end
      end
      if (rd_valid) begin
         total++;
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_read: got %h, none expected", rd_data);
         end else begin
            re = rq.pop_front();
            if (rd_data !== re.dat) begin
               bad++;
               $display("FAIL %s: got %h, want %h", re.name, rd_data, re.dat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wr_data = d;
      tick();
      wr_en = 1'b0; wr_data = '0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      rexp_t e;
      e.dat = exp; e.name = name;
      rq.push_back(e);
      rd_en = 1'b1; addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic ack(input logic [7:0] vec, input logic spur, input string name);
      vexp_t e;
      e.vec = vec; e.spur = spur; e.name = name;
      vq.push_back(e);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200us");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; irq_in = '0; wr_en = 1'b0; rd_en = 1'b0;
      addr = '0; wr_data = '0; int_ack = 1'b0;
      repeat (2) tick();
      chk("rst_int_out", 32'(int_out), 0);
      chk("rst_vector_valid", 32'(vector_valid), 0);
      chk("rst_vector_out", 32'(vector_out), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      reset = 1'b0;
      tick();
      rd(3'd0, 32'h00, "rst_ctrl");
      rd(3'd1, 32'hFF, "rst_mask");
      rd(3'd2, 32'h00, "rst_vbase");
      rd(3'd4, 32'h00, "rst_irr");
      rd(3'd6, 32'h00, "rst_prio");

      // Single channel: two-cycle request latency, ack vector and ISR.
      wr(3'd1, 32'hFE);
      irq_in = 8'h01;
      tick();
      chk("t1_int_lat1", 32'(int_out), 0);
      irq_in = 8'h00;
      tick();
      chk("t1_int_lat2", 32'(int_out), 1);
      ack(8'h00, 1'b0, "t1_vec");
      chk("t1_int_after_ack", 32'(int_out), 0);
      rd(3'd5, 32'h01, "t1_isr");
      rd(3'd4, 32'h00, "t1_irr");
      wr(3'd3, 32'h0);

      // Fixed priority with nesting.
      wr(3'd2, 32'h20);
      wr(3'd1, 32'h00);
      irq_in = 8'h28;
      repeat (2) tick();
      chk("t2_int_3_5", 32'(int_out), 1);
      ack(8'h23, 1'b0, "t2_vec3");
      rd(3'd4, 32'h20, "t2_irr_5_pending");
      tick();
      chk("t2_5_blocked", 32'(int_out), 0);
      irq_in = 8'h2A;
      repeat (2) tick();
      chk("t2_int_nested1", 32'(int_out), 1);
      ack(8'h21, 1'b0, "t2_vec1");
      rd(3'd5, 32'h0A, "t2_isr_0a");
      wr(3'd3, 32'h0);
      tick();
      chk("t2_5_blocked_eoi1", 32'(int_out), 0);
      wr(3'd3, 32'h0);
      tick();
      chk("t2_5_free_eoi2", 32'(int_out), 1);
      ack(8'h25, 1'b0, "t2_vec5");
      wr(3'd3, 32'h0);
      irq_in = 8'h00;

      // Rotating priority.
      wr(3'd0, 32'h4);
      irq_in = 8'h04;
      tick();
      irq_in = 8'h00;
      tick();
      chk("t3_int_ch2", 32'(int_out), 1);
      ack(8'h22, 1'b0, "t3_vec2");
      wr(3'd3, 32'h102);
      rd(3'd6, 32'h2, "t3_prio_2");
      irq_in = 8'h0C;
      repeat (2) tick();
      ack(8'h23, 1'b0, "t3_vec3_rot");
      irq_in = 8'h00;
      wr(3'd3, 32'h103);
      tick();
      chk("t3_int_ch2_after_eoi3", 32'(int_out), 1);
      ack(8'h22, 1'b0, "t3_vec2_again");
      wr(3'd3, 32'h0);
      rd(3'd6, 32'h2, "t3_prio_nseoi");
      rd(3'd5, 32'h0, "t3_isr_clear");

      // Level mode: request withdrawn before ack gives a spurious vector.
      wr(3'd0, 32'h1);
      irq_in = 8'h10;
      repeat (2) tick();
      chk("t4_int_level", 32'(int_out), 1);
      irq_in = 8'h00;
      repeat (2) tick();
      chk("t4_int_dropped", 32'(int_out), 0);
      ack(8'h27, 1'b1, "t4_spurious");
      rd(3'd5, 32'h0, "t4_isr_unchanged");

      // Auto-EOI in edge mode with request held high.
      wr(3'd0, 32'h2);
      irq_in = 8'h40;
      repeat (2) tick();
      chk("t5_int_ch6", 32'(int_out), 1);
      ack(8'h26, 1'b0, "t5_vec6");
      rd(3'd5, 32'h0, "t5_isr_auto");
      repeat (3) tick();
      chk("t5_no_rerequest", 32'(int_out), 0);
      rd(3'd4, 32'h0, "t5_irr_clear");

      // Reset landing on an ack/read cycle.
      irq_in = 8'h00;
      wr(3'd0, 32'h0);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      tick();
      ack(8'h20, 1'b0, "t6_vec0");
      irq_in = 8'h02;
      tick();
      irq_in = 8'h00;
      tick();
      rd(3'd4, 32'h02, "t6_irr_pre");
      rd(3'd5, 32'h01, "t6_isr_pre");
      int_ack = 1'b1; rd_en = 1'b1; addr = 3'd1;
      tick();
      reset = 1'b1; int_ack = 1'b0; rd_en = 1'b0;
      #1;
      chk("t6_vv_dropped", 32'(vector_valid), 0);
      chk("t6_rv_dropped", 32'(rd_valid), 0);
      chk("t6_spur_dropped", 32'(spurious), 0);
      tick();
      reset = 1'b0;
      tick();
      rd(3'd1, 32'hFF, "t6_mask");
      rd(3'd4, 32'h00, "t6_irr");
      rd(3'd5, 32'h00, "t6_isr");
      rd(3'd0, 32'h00, "t6_ctrl");
      repeat (3) tick();
      chk("vec_queue_drained", 32'(vq.size()), 0);
      chk("rd_queue_drained", 32'(rq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
